// File: rtl/mux_arb_nto1.sv
// N-channel W-bit selector with valid/ready handshake and a registered output stage.
// Directed mode forwards SELECT; round-robin mode scans from a rotating pointer.
module mux_arb_nto1 #(
    parameter int WIDTH    = 128,
    parameter int CHANNELS = 16,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          select,
    input  logic                      arb_mode,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_channel
);

    localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(CHANNELS);

    logic [WIDTH-1:0]    out_data_reg;
    logic                out_valid_reg;
    logic [SEL_W-1:0]    out_channel_reg;
    logic [SEL_W-1:0]    ptr_reg;
    logic [SEL_W-1:0]    ptr_next;

    logic                load;
    logic                dir_valid;
    logic                rr_valid;
    logic [SEL_W-1:0]    rr_grant;
    logic                grant_valid;
    logic [SEL_W-1:0]    grant;
    logic                transfer;
    logic [CHANNELS-1:0] scan_valid;
    logic [SEL_W-1:0]    scan_idx [CHANNELS];

    assign load = !out_valid_reg || out_ready;

    // scan_idx[k] is the channel visited k steps after the pointer, wrapping at CHANNELS
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_scan
            logic [SEL_W:0] sum;
            assign sum            = {1'b0, ptr_reg} + (SEL_W+1)'(gi);
            assign scan_idx[gi]   = (sum >= CH_LIMIT) ? SEL_W'(sum - CH_LIMIT) : sum[SEL_W-1:0];
            assign scan_valid[gi] = in_valid[scan_idx[gi]];
        end
    endgenerate

    always_comb begin
        rr_valid = 1'b0;
        rr_grant = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (scan_valid[k]) begin
                rr_valid = 1'b1;
                rr_grant = scan_idx[k];
            end
        end
    end

    // Compare against every legal index so an out-of-range SELECT can never grant
    always_comb begin
        dir_valid = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (({1'b0, select} == (SEL_W+1)'(k)) && in_valid[k]) begin
                dir_valid = 1'b1;
            end
        end
    end

    assign grant_valid = arb_mode ? rr_valid : dir_valid;
    assign grant       = arb_mode ? rr_grant : select;
    assign transfer    = load && grant_valid;
    assign ptr_next    = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign in_ready[gi] = !reset && transfer && (grant == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_reg    <= '0;
            out_valid_reg   <= 1'b0;
            out_channel_reg <= '0;
            ptr_reg         <= '0;
        end else if (load) begin
            out_valid_reg <= grant_valid;
            if (grant_valid) begin
                out_data_reg    <= in_data[grant*WIDTH +: WIDTH];
                out_channel_reg <= grant;
                if (arb_mode) begin
                    ptr_reg <= ptr_next;
                end
            end
        end
    end

    assign out_data    = out_data_reg;
    assign out_valid   = out_valid_reg;
    assign out_channel = out_channel_reg;

endmodule
